// File: rtl/output_sram_arbiter.sv
// Round-robin arbiter sharing one output-SRAM write port among NUM_BANK edge-buffer banks.
// A bank wins a one-cycle grant, then owns the port until its eos beat; beats land one cycle later.
module output_sram_arbiter #(
    parameter int NUM_BANK = 4,
    parameter int DATA_W   = 16,
    parameter int NODE_W   = 8,
    parameter int BEAT_W   = 4,
    localparam int OWN_W   = $clog2(NUM_BANK)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_BANK-1:0]          bank_req,
    input  logic [NUM_BANK-1:0]          bank_valid,
    input  logic [NUM_BANK-1:0]          bank_sos,
    input  logic [NUM_BANK-1:0]          bank_eos,
    input  logic [NUM_BANK*DATA_W-1:0]   bank_data,
    input  logic [NUM_BANK*NODE_W-1:0]   bank_node_id,
    output logic [NUM_BANK-1:0]          bank_grant,
    output logic                         sram_wr_en,
    output logic [DATA_W-1:0]            sram_data,
    output logic [NODE_W-1:0]            sram_node_id,
    output logic [BEAT_W-1:0]            sram_beat_idx,
    output logic                         arb_busy,
    output logic [OWN_W-1:0]             owner,
    output logic                         protocol_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_STREAM} state_t;

    state_t              state_q;
    logic [OWN_W-1:0]    owner_q;
    logic [OWN_W-1:0]    rr_ptr_q;
    logic [BEAT_W-1:0]   beat_cnt_q;
    logic [NUM_BANK-1:0] bank_grant_q;
    logic                sram_wr_en_q;
    logic [DATA_W-1:0]   sram_data_q;
    logic [NODE_W-1:0]   sram_node_id_q;
    logic [BEAT_W-1:0]   sram_beat_idx_q;
    logic                protocol_err_q;

    logic [DATA_W-1:0]   data_arr [NUM_BANK];
    logic [NODE_W-1:0]   node_arr [NUM_BANK];

    generate
        for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_unpack
            assign data_arr[gi] = bank_data[gi*DATA_W +: DATA_W];
            assign node_arr[gi] = bank_node_id[gi*NODE_W +: NODE_W];
        end
    endgenerate

    logic own_valid, own_sos, own_eos;
    assign own_valid = bank_valid[owner_q];
    assign own_sos   = bank_sos[owner_q];
    assign own_eos   = bank_eos[owner_q];

    // Search starts just above the last served bank, so it has lowest priority.
    logic             found_d;
    logic [OWN_W-1:0] next_owner_d;
    logic [OWN_W-1:0] cand;
    always_comb begin
        found_d      = 1'b0;
        next_owner_d = '0;
        cand         = '0;
        for (int k = 1; k <= NUM_BANK; k++) begin
            cand = OWN_W'((int'(rr_ptr_q) + k) % NUM_BANK);
            if (!found_d && bank_req[cand]) begin
                found_d      = 1'b1;
                next_owner_d = cand;
            end
        end
    end

    logic [BEAT_W-1:0] beat_idx_d;
    assign beat_idx_d = own_sos ? '0 : beat_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            owner_q         <= '0;
            rr_ptr_q        <= OWN_W'(NUM_BANK - 1);
            beat_cnt_q      <= '0;
            bank_grant_q    <= '0;
            sram_wr_en_q    <= 1'b0;
            sram_data_q     <= '0;
            sram_node_id_q  <= '0;
            sram_beat_idx_q <= '0;
            protocol_err_q  <= 1'b0;
        end else begin
            sram_wr_en_q <= 1'b0;
            bank_grant_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        owner_q      <= next_owner_d;
                        bank_grant_q <= {{(NUM_BANK-1){1'b0}}, 1'b1} << next_owner_d;
                        state_q      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    rr_ptr_q <= owner_q;
                    if (own_valid && own_sos) begin
                        sram_wr_en_q    <= 1'b1;
                        sram_data_q     <= data_arr[owner_q];
                        sram_node_id_q  <= node_arr[owner_q];
                        sram_beat_idx_q <= beat_idx_d;
                        beat_cnt_q      <= beat_idx_d + 1'b1;
                        state_q         <= own_eos ? ST_IDLE : ST_STREAM;
                    end else begin
                        protocol_err_q  <= 1'b1;
                        state_q         <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (own_valid) begin
                        sram_wr_en_q    <= 1'b1;
                        sram_data_q     <= data_arr[owner_q];
                        sram_node_id_q  <= node_arr[owner_q];
                        sram_beat_idx_q <= beat_idx_d;
                        beat_cnt_q      <= beat_idx_d + 1'b1;
                        if (own_sos) protocol_err_q <= 1'b1;
                        if (own_eos) state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bank_grant    = bank_grant_q;
    assign sram_wr_en    = sram_wr_en_q;
    assign sram_data     = sram_data_q;
    assign sram_node_id  = sram_node_id_q;
    assign sram_beat_idx = sram_beat_idx_q;
    assign arb_busy      = (state_q != ST_IDLE);
    assign owner         = owner_q;
    assign protocol_err  = protocol_err_q;

endmodule

// File: tb/tb_output_sram_arbiter.sv
// Self-checking bench for output_sram_arbiter: table-driven single stream plus hand-written
// round-robin, stall, single-beat, protocol-error and reset-mid-stream sequences.
module tb_output_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  bank_req, bank_valid, bank_sos, bank_eos;
    logic [63:0] bank_data;
    logic [31:0] bank_node_id;
    logic [3:0]  bank_grant;
    logic        sram_wr_en;
    logic [15:0] sram_data;
    logic [7:0]  sram_node_id;
    logic [3:0]  sram_beat_idx;
    logic        arb_busy;
    logic [1:0]  owner;
    logic        protocol_err;

    always #5 clk = ~clk;

    output_sram_arbiter #(.NUM_BANK(4), .DATA_W(16), .NODE_W(8), .BEAT_W(4)) dut (
        .clk(clk), .reset(reset),
        .bank_req(bank_req), .bank_valid(bank_valid), .bank_sos(bank_sos), .bank_eos(bank_eos),
        .bank_data(bank_data), .bank_node_id(bank_node_id),
        .bank_grant(bank_grant), .sram_wr_en(sram_wr_en), .sram_data(sram_data),
        .sram_node_id(sram_node_id), .sram_beat_idx(sram_beat_idx),
        .arb_busy(arb_busy), .owner(owner), .protocol_err(protocol_err)
    );

    typedef struct {
        logic [15:0] d;
        logic [7:0]  n;
        logic [3:0]  idx;
    } wr_t;

    typedef struct {
        logic [3:0]  req;
        int          lane;
        logic        v, s, e;
        logic [15:0] d;
        logic [7:0]  n;
        logic        push;
        logic [3:0]  idx;
        logic [3:0]  exp_grant;
        logic        exp_busy;
        logic [1:0]  exp_owner;
    } vec_t;

    wr_t  sb_q[$];
    vec_t tbl[6];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon();
        wr_t e;
        if (sram_wr_en === 1'b1) begin
            $display("write data=%04h node=%02h idx=%0d", sram_data, sram_node_id, sram_beat_idx);
            if (sb_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: got data %04h idx %0d expected no write", sram_data, sram_beat_idx);
            end else begin
                e = sb_q.pop_front();
                chk("wr_data", 32'(sram_data), 32'(e.d));
                chk("wr_node", 32'(sram_node_id), 32'(e.n));
                chk("wr_idx", 32'(sram_beat_idx), 32'(e.idx));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
    endtask

    task automatic push(input logic [15:0] d, input logic [7:0] n, input logic [3:0] idx);
        wr_t e;
        e.d = d; e.n = n; e.idx = idx;
        sb_q.push_back(e);
    endtask

    // Non-selected lanes always carry valid/sos/eos noise with inverted data.
    task automatic drive(input logic [3:0] req, input int lane, input logic v, input logic s,
                         input logic e, input logic [15:0] d, input logic [7:0] n);
        bank_req = req;
        for (int i = 0; i < 4; i++) begin
            if (i == lane) begin
                bank_valid[i] = v; bank_sos[i] = s; bank_eos[i] = e;
                bank_data[i*16 +: 16]  = d;
                bank_node_id[i*8 +: 8] = n;
            end else begin
                bank_valid[i] = 1'b1; bank_sos[i] = 1'b1; bank_eos[i] = 1'b1;
                bank_data[i*16 +: 16]  = ~d;
                bank_node_id[i*8 +: 8] = ~n;
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, 32'(bank_grant), 32'h0);
        chk({tag, "_wr_en"}, 32'(sram_wr_en), 32'h0);
        chk({tag, "_data"}, 32'(sram_data), 32'h0);
        chk({tag, "_node"}, 32'(sram_node_id), 32'h0);
        chk({tag, "_idx"}, 32'(sram_beat_idx), 32'h0);
        chk({tag, "_busy"}, 32'(arb_busy), 32'h0);
        chk({tag, "_owner"}, 32'(owner), 32'h0);
        chk({tag, "_err"}, 32'(protocol_err), 32'h0);
    endtask

    initial begin
        tbl[0] = '{4'b0100, 2, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 4'd0, 4'b0000, 1'b0, 2'd0};
        tbl[1] = '{4'b0000, 2, 1'b1, 1'b1, 1'b0, 16'h0102, 8'h2A, 1'b1, 4'd0, 4'b0100, 1'b1, 2'd2};
        tbl[2] = '{4'b0000, 2, 1'b1, 1'b0, 1'b0, 16'h0304, 8'h2A, 1'b1, 4'd1, 4'b0000, 1'b1, 2'd2};
        tbl[3] = '{4'b0000, 2, 1'b1, 1'b0, 1'b1, 16'h0506, 8'h2A, 1'b1, 4'd2, 4'b0000, 1'b1, 2'd2};
        tbl[4] = '{4'b0000, 2, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 4'd0, 4'b0000, 1'b0, 2'd2};
        tbl[5] = '{4'b0000, 2, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 4'd0, 4'b0000, 1'b0, 2'd2};

        // Reset state
        reset = 1'b0;
        drive(4'b0000, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        tick();
        chk_zero("reset");
        reset = 1'b1;
        drive(4'b0000, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);

        // Single request from bank 2, 3-beat stream
        for (int r = 0; r < 6; r++) begin
            tick();
            chk("tbl_grant", 32'(bank_grant), 32'(tbl[r].exp_grant));
            chk("tbl_busy", 32'(arb_busy), 32'(tbl[r].exp_busy));
            chk("tbl_owner", 32'(owner), 32'(tbl[r].exp_owner));
            drive(tbl[r].req, tbl[r].lane, tbl[r].v, tbl[r].s, tbl[r].e, tbl[r].d, tbl[r].n);
            if (tbl[r].push) push(tbl[r].d, tbl[r].n, tbl[r].idx);
        end
        chk("tbl_drained", 32'(sb_q.size()), 32'h0);

        // All banks request: grants 0,1,2,3,0 with one idle cycle after each eos
        reset = 1'b0;
        tick();
        reset = 1'b1;
        drive(4'b1111, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_grant", 32'(bank_grant), 32'(4'b0001 << (k % 4)));
            chk("rr_owner", 32'(owner), 32'(k % 4));
            chk("rr_busy_g", 32'(arb_busy), 32'h1);
            drive(4'b1111, k % 4, 1'b1, 1'b1, 1'b0, 16'hA000 + 16'(k), 8'h10 + 8'(k));
            push(16'hA000 + 16'(k), 8'h10 + 8'(k), 4'd0);
            tick();
            chk("rr_grant_s", 32'(bank_grant), 32'h0);
            drive(4'b1111, k % 4, 1'b1, 1'b0, 1'b1, 16'hB000 + 16'(k), 8'h10 + 8'(k));
            push(16'hB000 + 16'(k), 8'h10 + 8'(k), 4'd1);
            tick();
            chk("rr_idle_busy", 32'(arb_busy), 32'h0);
            chk("rr_idle_grant", 32'(bank_grant), 32'h0);
            drive((k == 4) ? 4'b0000 : 4'b1111, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        end
        tick();
        chk("rr_drained", 32'(sb_q.size()), 32'h0);

        // Stall mid-stream with non-owner noise
        drive(4'b0010, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        chk("stall_grant", 32'(bank_grant), 32'b0010);
        drive(4'b0000, 1, 1'b1, 1'b1, 1'b0, 16'hA1A1, 8'h31);
        push(16'hA1A1, 8'h31, 4'd0);
        tick();
        drive(4'b0000, 1, 1'b1, 1'b0, 1'b0, 16'hA2A2, 8'h31);
        push(16'hA2A2, 8'h31, 4'd1);
        tick();
        drive(4'b0000, 1, 1'b0, 1'b0, 1'b0, 16'hA9A9, 8'h31);
        tick();
        chk("stall_busy", 32'(arb_busy), 32'h1);
        drive(4'b0000, 1, 1'b0, 1'b0, 1'b0, 16'hA9A9, 8'h31);
        tick();
        chk("stall_no_wr", 32'(sram_wr_en), 32'h0);
        chk("stall_busy2", 32'(arb_busy), 32'h1);
        drive(4'b0000, 1, 1'b1, 1'b0, 1'b0, 16'hA3A3, 8'h31);
        push(16'hA3A3, 8'h31, 4'd2);
        tick();
        drive(4'b0000, 1, 1'b1, 1'b0, 1'b1, 16'hA4A4, 8'h31);
        push(16'hA4A4, 8'h31, 4'd3);
        tick();
        chk("stall_end_busy", 32'(arb_busy), 32'h0);
        drive(4'b0000, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        chk("stall_drained", 32'(sb_q.size()), 32'h0);

        // Single-beat stream from bank 0
        drive(4'b0001, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        chk("single_grant", 32'(bank_grant), 32'b0001);
        chk("single_owner", 32'(owner), 32'h0);
        drive(4'b0000, 0, 1'b1, 1'b1, 1'b1, 16'hB1B1, 8'h44);
        push(16'hB1B1, 8'h44, 4'd0);
        tick();
        chk("single_busy", 32'(arb_busy), 32'h0);
        chk("single_wr", 32'(sram_wr_en), 32'h1);
        drive(4'b0000, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        chk("single_wr_off", 32'(sram_wr_en), 32'h0);
        chk("single_drained", 32'(sb_q.size()), 32'h0);

        // Protocol error: bank 3 not valid in its grant cycle
        drive(4'b1000, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        chk("perr_grant", 32'(bank_grant), 32'b1000);
        chk("perr_err_pre", 32'(protocol_err), 32'h0);
        drive(4'b0000, 3, 1'b0, 1'b0, 1'b0, 16'hDEAD, 8'h55);
        tick();
        chk("perr_err", 32'(protocol_err), 32'h1);
        chk("perr_busy", 32'(arb_busy), 32'h0);
        chk("perr_no_wr", 32'(sram_wr_en), 32'h0);
        drive(4'b0100, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        chk("perr_next_grant", 32'(bank_grant), 32'b0100);
        chk("perr_next_owner", 32'(owner), 32'h2);
        drive(4'b0000, 2, 1'b1, 1'b1, 1'b1, 16'hC1C1, 8'h66);
        push(16'hC1C1, 8'h66, 4'd0);
        tick();
        drive(4'b0000, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        chk("perr_sticky", 32'(protocol_err), 32'h1);
        chk("perr_drained", 32'(sb_q.size()), 32'h0);

        // Reset mid-stream, then bank 3 alone
        drive(4'b0010, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        chk("rst_grant", 32'(bank_grant), 32'b0010);
        drive(4'b0000, 1, 1'b1, 1'b1, 1'b0, 16'hD1D1, 8'h77);
        push(16'hD1D1, 8'h77, 4'd0);
        tick();
        drive(4'b0000, 1, 1'b1, 1'b0, 1'b0, 16'hD2D2, 8'h77);
        push(16'hD2D2, 8'h77, 4'd1);
        tick();
        drive(4'b0000, 1, 1'b1, 1'b0, 1'b0, 16'hD3D3, 8'h77);
        reset = 1'b0;
        tick();
        chk_zero("rst_mid");
        reset = 1'b1;
        drive(4'b1000, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        chk("rst_next_grant", 32'(bank_grant), 32'b1000);
        chk("rst_next_owner", 32'(owner), 32'h3);
        drive(4'b0000, 3, 1'b1, 1'b1, 1'b1, 16'hE1E1, 8'h88);
        push(16'hE1E1, 8'h88, 4'd0);
        tick();
        drive(4'b0000, -1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        chk("rst_drained", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/output_sram_arbiter.md
# output_sram_arbiter

Round-robin arbiter that shares the single output-buffer SRAM write port among `NUM_BANK` edge-buffer banks. Each bank raises a request when it holds a completed partial aggregation to write back. The arbiter issues a one-cycle grant to one bank, then forwards that bank's 2-feature beats (sos…eos) to the SRAM write port with one registered cycle of latency. It holds ownership until the stream's eos beat.

## Interface
Parameters:
- `NUM_BANK`, 4: number of requesting banks (≥2).
- `DATA_W`, 16: beat width, two 8-bit feature values.
- `NODE_W`, 8: node-id width.
- `BEAT_W`, 4: beat index counter width.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `reset`  in  1: synchronous, active-low.
- `bank_req`  in  NUM_BANK: per-bank write-back request; held until granted.
- `bank_valid`  in  NUM_BANK: per-bank beat valid (bank's Grant_valid).
- `bank_sos`  in  NUM_BANK: per-bank start of stream.
- `bank_eos`  in  NUM_BANK: per-bank end of stream.
- `bank_data`  in  NUM_BANK*DATA_W: bank i occupies bits [i*DATA_W +: DATA_W].
- `bank_node_id`  in  NUM_BANK*NODE_W: bank i occupies bits [i*NODE_W +: NODE_W].
- `bank_grant`  out  NUM_BANK: one-hot, one-cycle grant pulse.
- `sram_wr_en`  out  1: write strobe to the output SRAM.
- `sram_data`  out  DATA_W: write data.
- `sram_node_id`  out  NODE_W: node id of the write.
- `sram_beat_idx`  out  BEAT_W: beat index within the stream, 0 at sos.
- `arb_busy`  out  1: high in GRANT and STREAM states.
- `owner`  out  $clog2(NUM_BANK): current or last owner index.
- `protocol_err`  out  1: sticky error flag; cleared only by reset.

## Operation
- **Reset (reset=0 at posedge):**
  - State = IDLE.
  - All outputs = 0.
  - `rr_ptr` = NUM_BANK-1, so bank 0 has first priority.
  - Beat counter = 0.
- **IDLE:**
  - If `bank_req` is nonzero, select the first set bit searching upward from `rr_ptr+1`, wrapping modulo NUM_BANK.
  - Register `owner`. Drive `bank_grant[owner]`=1 next cycle. Go to GRANT.
  - If `bank_req` is zero, stay in IDLE.
- **GRANT** (one cycle; `bank_grant` high only here). The owner bank drives its first beat in this same cycle.
  - If `bank_valid[owner]` and `bank_sos[owner]`: forward the beat.
    - If `bank_eos[owner]` is also set, go to IDLE; otherwise go to STREAM.
  - If not valid, or valid without sos: set `protocol_err`, write nothing, go to IDLE.
  - In both cases set `rr_ptr` = owner.
- **STREAM:**
  - Each cycle with `bank_valid[owner]`=1, forward the beat.
  - A forwarded beat with eos returns the arbiter to IDLE.
  - `bank_valid[owner]`=0 is a stall: nothing is written and the arbiter stays in STREAM.
  - `bank_sos[owner]`=1 in STREAM sets `protocol_err`; the beat is still forwarded.
- **Forwarding a beat:** on the next cycle, `sram_wr_en`=1, `sram_data`/`sram_node_id` = owner's inputs, `sram_beat_idx` = counter.
  - The counter increments per forwarded beat, resets to 0 on sos, and wraps modulo 2^BEAT_W.
- **Non-owner banks:** valid/sos/eos/data from non-owners are ignored at all times. Requests from non-owners stay pending.
- **Registered outputs:** `sram_*` outputs are registered. `sram_wr_en` is 0 on every cycle that follows a non-forwarding cycle. `sram_data`/`sram_node_id` hold their last value.

## Timing
- Request to grant: `bank_req` first seen high in IDLE at cycle t → `bank_grant` high at t+1.
- Beat to write: a beat accepted at cycle c → `sram_wr_en` at c+1.
- Back-to-back streams: eos at cycle e → IDLE at e+1 → next grant at e+2. Minimum one idle cycle between streams.
- Fairness: the bank just served has lowest priority in the next arbitration. With all banks requesting, the grant order is 0,1,2,3,0,….
- Simultaneous requests in IDLE: exactly one grant is issued. `bank_grant` is never more than one-hot.
- Reset mid-stream: the next cycle is IDLE with all outputs 0. The in-flight write (if any) is dropped, and `rr_ptr` returns to NUM_BANK-1.
- Single-beat stream (sos and eos in the GRANT cycle): one write, then IDLE; STREAM is never entered.

## Test plan
- **Single request:** `bank_req`=4'b0100 at t.
  - Expect `bank_grant`=4'b0100 at t+1.
  - Bank drives 3 beats (sos at t+1, eos at t+3), data 16'h0102/0304/0506, node 8'h2A.
  - Expect `sram_wr_en` at t+2..t+4 with `sram_beat_idx` 0,1,2, then IDLE.
- **All four banks request continuously:** each stream is 2 beats. Grants go to banks 0,1,2,3,0, with exactly one idle cycle after each eos.
- **Stall mid-stream:** owner drops `bank_valid` for 2 cycles in STREAM. Expect no write in those cycles and the beat index resumes without a gap. A non-owner's valid beats during the stall produce no write.
- **Single-beat stream:** sos+eos in the GRANT cycle → exactly one write with idx 0; `arb_busy` falls the next cycle.
- **Protocol error:** the granted bank is not valid in the GRANT cycle → `protocol_err`=1 persists, no write occurs, the arbiter returns to IDLE, and the next requester is granted normally.
- **Reset mid-stream:** reset=0 for one cycle during STREAM → all outputs 0, state IDLE. The following request from bank 3 (only requester) is granted normally.
